// File: rtl/qos_fifo_bank.sv
// qos_fifo_bank: QUEUE_QUANTITY independent circular FIFOs with occupancy, thresholds and sticky errors.
// Latency: accepted pop -> data_out/data_out_valid one cycle later; status flags combinational from count.
// Backpressure: none upstream; full-queue pushes are dropped (overflow_err), empty-queue pops flag underflow_err.
//
// Ports:
//   clk, rst (sync, active-high, wins over enb), enb (0 freezes state, data_out_valid drops)
//   push/pop        per-queue strobes; data_in/data_out sliced [i*DATA_BITS +: DATA_BITS]
//   umbral_alto/bajo shared almost-full / almost-empty thresholds
//   count           per-queue occupancy, sliced [i*CNT_BITS +: CNT_BITS]
//   full/empty/almost_full/almost_empty  per-queue status
//   err_clr         clears sticky overflow_err/underflow_err (acts even when enb=0)
// Optional macro QOS_FIFO_ERR_COUNT_EN adds err_count: saturating 8-bit error counter per queue.
module qos_fifo_bank #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int BUF_WIDTH      = 3,
  parameter int CNT_BITS       = BUF_WIDTH + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           push,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  input  logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_out,
  output logic [QUEUE_QUANTITY-1:0]           data_out_valid,
  input  logic [CNT_BITS-1:0]                 umbral_alto,
  input  logic [CNT_BITS-1:0]                 umbral_bajo,
  output logic [QUEUE_QUANTITY*CNT_BITS-1:0]  count,
  output logic [QUEUE_QUANTITY-1:0]           full,
  output logic [QUEUE_QUANTITY-1:0]           empty,
  output logic [QUEUE_QUANTITY-1:0]           almost_full,
  output logic [QUEUE_QUANTITY-1:0]           almost_empty,
  input  logic                                err_clr,
  output logic [QUEUE_QUANTITY-1:0]           overflow_err,
  output logic [QUEUE_QUANTITY-1:0]           underflow_err
`ifdef QOS_FIFO_ERR_COUNT_EN
  ,
  output logic [QUEUE_QUANTITY*8-1:0]         err_count
`endif
);

  localparam int DEPTH = 1 << BUF_WIDTH;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  logic [DATA_BITS-1:0] mem_q      [QUEUE_QUANTITY][DEPTH];
  logic [DATA_BITS-1:0] mem_d      [QUEUE_QUANTITY][DEPTH];
  logic [BUF_WIDTH-1:0] wr_ptr_q   [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] wr_ptr_d   [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] rd_ptr_q   [QUEUE_QUANTITY];
  logic [BUF_WIDTH-1:0] rd_ptr_d   [QUEUE_QUANTITY];
  logic [CNT_BITS-1:0]  count_q    [QUEUE_QUANTITY];
  logic [CNT_BITS-1:0]  count_d    [QUEUE_QUANTITY];
  logic [DATA_BITS-1:0] data_out_q [QUEUE_QUANTITY];
  logic [DATA_BITS-1:0] data_out_d [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] dvld_q, dvld_d;
  logic [QUEUE_QUANTITY-1:0] ovf_q, ovf_d;
  logic [QUEUE_QUANTITY-1:0] udf_q, udf_d;
  logic [QUEUE_QUANTITY-1:0] push_acc, pop_acc, ovf_evt, udf_evt;

  // Acceptance: a pop is taken only from a non-empty queue, so a push to an
  // empty queue never bypasses into the read path. A full queue still accepts
  // a push when its pop is accepted in the same cycle.
  always_comb begin
    push_acc = '0;
    pop_acc  = '0;
    ovf_evt  = '0;
    udf_evt  = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      pop_acc[i]  = enb & pop[i] & (count_q[i] != '0);
      push_acc[i] = enb & push[i] & ((count_q[i] != DEPTH_C) | pop_acc[i]);
      ovf_evt[i]  = enb & push[i] & ~push_acc[i];
      udf_evt[i]  = enb & pop[i] & ~pop_acc[i];
    end
  end

  always_comb begin
    mem_d  = mem_q;
    dvld_d = pop_acc;
    ovf_d  = '0;
    udf_d  = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      wr_ptr_d[i]   = wr_ptr_q[i] + BUF_WIDTH'(push_acc[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + BUF_WIDTH'(pop_acc[i]);
      count_d[i]    = count_q[i] + CNT_BITS'(push_acc[i]) - CNT_BITS'(pop_acc[i]);
      data_out_d[i] = pop_acc[i] ? mem_q[i][rd_ptr_q[i]] : data_out_q[i];
      if (push_acc[i]) begin
        mem_d[i][wr_ptr_q[i]] = data_in[i*DATA_BITS +: DATA_BITS];
      end
      // A new error in the clearing cycle keeps the flag set.
      ovf_d[i] = ovf_evt[i] | (ovf_q[i] & ~err_clr);
      udf_d[i] = udf_evt[i] | (udf_q[i] & ~err_clr);
    end
  end

  // Storage is never reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        count_q[i]    <= '0;
        data_out_q[i] <= '0;
      end
      dvld_q <= '0;
      ovf_q  <= '0;
      udf_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      dvld_q     <= dvld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_comb begin
    data_out     = '0;
    count        = '0;
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      data_out[i*DATA_BITS +: DATA_BITS] = data_out_q[i];
      count[i*CNT_BITS +: CNT_BITS]      = count_q[i];
      full[i]         = (count_q[i] == DEPTH_C);
      empty[i]        = (count_q[i] == '0);
      almost_full[i]  = (count_q[i] >= umbral_alto);
      almost_empty[i] = (count_q[i] <= umbral_bajo);
    end
  end

  assign data_out_valid = dvld_q;
  assign overflow_err   = ovf_q;
  assign underflow_err  = udf_q;

`ifdef QOS_FIFO_ERR_COUNT_EN
  logic [7:0] err_cnt_q [QUEUE_QUANTITY];
  logic [7:0] err_cnt_d [QUEUE_QUANTITY];

  // At most one of overflow/underflow can occur per queue per cycle
  // (a queue cannot be both full and empty), so a single increment suffices.
  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      err_cnt_d[i] = err_cnt_q[i];
      if (err_clr) begin
        err_cnt_d[i] = (ovf_evt[i] | udf_evt[i]) ? 8'd1 : 8'd0;
      end else if ((ovf_evt[i] | udf_evt[i]) && (err_cnt_q[i] != 8'hFF)) begin
        err_cnt_d[i] = err_cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        err_cnt_q[i] <= '0;
      end
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    err_count = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      err_count[i*8 +: 8] = err_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_qos_fifo_bank.sv
module tb_qos_fifo_bank;

  logic        clk = 1'b0;
  logic        rst, enb, err_clr;
  logic [3:0]  push, pop;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_out_valid;
  logic [3:0]  umbral_alto, umbral_bajo;
  logic [15:0] count;
  logic [3:0]  full, empty, almost_full, almost_empty;
  logic [3:0]  overflow_err, underflow_err;
`ifdef QOS_FIFO_ERR_COUNT_EN
  logic [31:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qos_fifo_bank dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .push           (push),
    .data_in        (data_in),
    .pop            (pop),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .umbral_alto    (umbral_alto),
    .umbral_bajo    (umbral_bajo),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .err_clr        (err_clr),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
`ifdef QOS_FIFO_ERR_COUNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cnt_of(input int q);
    return count[q*4 +: 4];
  endfunction

  function automatic logic [7:0] dout_of(input int q);
    return data_out[q*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; enb = 1'b1; err_clr = 1'b0;
    push = '0; pop = '0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;

    // Reset and idle
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_dout", data_out, 32'h0);
    chk("rst_dvld", 32'(data_out_valid), 32'h0);
    chk("rst_ovf", 32'(overflow_err), 32'h0);
    chk("rst_udf", 32'(underflow_err), 32'h0);
    chk("rst_aempty", 32'(almost_empty), 32'hF);
    chk("rst_afull", 32'(almost_full), 32'h0);

    // Fill queue 2 with 0x11..0x18; almost_full at 6, full at 8
    for (int k = 0; k < 8; k++) begin
      push = 4'b0100;
      data_in = 32'(8'h11 + k) << 16;
      step();
      chk("q2_fill_count", 32'(cnt_of(2)), 32'(k + 1));
      chk("q2_fill_afull", 32'(almost_full[2]), 32'((k + 1) >= 6));
    end
    chk("q2_full_vec", 32'(full), 32'h4);
    push = 4'b0100; data_in = 32'h0099_0000;
    step();
    chk("q2_ovf_count", 32'(cnt_of(2)), 32'd8);
    chk("q2_ovf_flag", 32'(overflow_err), 32'h4);
    chk("q2_others_count", 32'(count & 16'hF0FF), 32'h0);
    push = '0;

    // Drain queue 2, order and almost_empty
    for (int k = 0; k < 8; k++) begin
      pop = 4'b0100;
      step();
      chk("q2_pop_data", 32'(dout_of(2)), 32'(8'h11 + k));
      chk("q2_pop_dvld", 32'(data_out_valid), 32'h4);
      chk("q2_pop_aempty", 32'(almost_empty[2]), 32'((7 - k) <= 2));
    end
    pop = '0;
    step();
    chk("q2_idle_dvld", 32'(data_out_valid), 32'h0);
    chk("q2_idle_hold", 32'(dout_of(2)), 32'h18);
    chk("q2_empty", 32'(empty[2]), 32'h1);

    // Fill queue 0, then push+pop while full across the pointer wrap
    for (int k = 0; k < 8; k++) begin
      push = 4'b0001; data_in = 32'(8'hA0 + k);
      step();
    end
    chk("q0_full", 32'(full), 32'h1);
    for (int k = 0; k < 10; k++) begin
      push = 4'b0001; pop = 4'b0001; data_in = 32'(8'hB0 + k);
      step();
      chk("q0_pp_count", 32'(cnt_of(0)), 32'd8);
      chk("q0_pp_data", 32'(dout_of(0)), (k < 8) ? 32'(8'hA0 + k) : 32'(8'hB0 + k - 8));
    end
    push = '0;
    for (int k = 0; k < 8; k++) begin
      pop = 4'b0001;
      step();
      chk("q0_drain_data", 32'(dout_of(0)), 32'(8'hB2 + k));
      chk("q0_drain_count", 32'(cnt_of(0)), 32'(7 - k));
    end
    pop = '0;
    chk("q0_no_ovf", 32'(overflow_err), 32'h4);

    // Pop empty queue 3 while pushing: pop rejected, push accepted
    push = 4'b1000; pop = 4'b1000; data_in = 32'hAA00_0000;
    step();
    chk("q3_udf", 32'(underflow_err), 32'h8);
    chk("q3_count", 32'(cnt_of(3)), 32'd1);
    chk("q3_dvld", 32'(data_out_valid), 32'h0);
    // err_clr coincident with a new underflow on queue 1
    push = '0; pop = 4'b0010; err_clr = 1'b1;
    step();
    chk("clr_udf", 32'(underflow_err), 32'h2);
    chk("clr_ovf", 32'(overflow_err), 32'h0);
    pop = '0; err_clr = 1'b0;

    // Queue 1 gets five words
    for (int k = 0; k < 5; k++) begin
      push = 4'b0010; data_in = 32'(8'h51 + k) << 8;
      step();
    end
    push = '0;
    chk("q1_count5", 32'(cnt_of(1)), 32'd5);

    // enb=0 freezes everything
    enb = 1'b0; push = 4'hF; pop = 4'hF; data_in = 32'hFFFF_FFFF;
    step(); step();
    chk("enb0_count", 32'(count), 32'h1050);
    chk("enb0_udf", 32'(underflow_err), 32'h2);
    chk("enb0_ovf", 32'(overflow_err), 32'h0);
    chk("enb0_dvld", 32'(data_out_valid), 32'h0);
    chk("enb0_dout", data_out, 32'h0018_00B9);
    enb = 1'b1; push = '0; pop = 4'b1000;
    step();
    chk("enb1_q3_data", 32'(dout_of(3)), 32'hAA);
    chk("enb1_q3_dvld", 32'(data_out_valid), 32'h8);
    chk("enb1_q3_count", 32'(cnt_of(3)), 32'd0);
    pop = '0;

    // Reset mid-operation with five words in queue 1
    rst = 1'b1;
    step();
    chk("rst2_count", 32'(count), 32'h0);
    chk("rst2_empty", 32'(empty), 32'hF);
    chk("rst2_dout", data_out, 32'h0);
    chk("rst2_udf", 32'(underflow_err), 32'h0);
    rst = 1'b0;
    step();

    // Threshold boundaries (combinational from thresholds)
    umbral_alto = 4'd0; #1;
    chk("alto0_afull", 32'(almost_full), 32'hF);
    umbral_alto = 4'd9; #1;
    chk("alto9_afull_empty", 32'(almost_full), 32'h0);
    for (int k = 0; k < 8; k++) begin
      push = 4'b0001; data_in = 32'(8'hC0 + k);
      step();
    end
    push = '0;
    chk("alto9_afull_full", 32'(almost_full), 32'h0);
    umbral_alto = 4'd8; #1;
    chk("alto8_afull", 32'(almost_full), 32'h1);
    umbral_bajo = 4'd8; #1;
    chk("bajo8_aempty", 32'(almost_empty), 32'hF);
    umbral_bajo = 4'd7; #1;
    chk("bajo7_aempty", 32'(almost_empty), 32'hE);

    // Overflow coincident with err_clr: new error wins
    push = 4'b0001; err_clr = 1'b1; data_in = 32'h0000_00EE;
    step();
    chk("clr_new_ovf", 32'(overflow_err), 32'h1);
    chk("clr_new_count", 32'(cnt_of(0)), 32'd8);
`ifdef QOS_FIFO_ERR_COUNT_EN
    chk("errcnt_load1", err_count, 32'h1);
`endif
    // err_clr acts while enb=0
    push = '0; enb = 1'b0;
    step();
    chk("clr_enb0_ovf", 32'(overflow_err), 32'h0);
`ifdef QOS_FIFO_ERR_COUNT_EN
    chk("errcnt_clr", err_count, 32'h0);
`endif
    err_clr = 1'b0; enb = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
